// File: rtl/itp_pkg.sv
// Shared types and helpers for the interpolator output packer.
package itp_pkg;

  localparam int ITP_SIZE_PIXEL = 8;
  localparam int ITP_SIZE_Y     = 10;

  typedef struct packed {
    logic       eof;
    logic       eol;
    logic [7:0] pix;
  } itp_out_word_t;

  // U8.2 -> U8 with round-half-up; an 11-bit sum keeps the carry that marks saturation.
  function automatic logic [7:0] itp_round_clamp(input logic [9:0] y);
    logic [10:0] sum;
    sum = {1'b0, y} + 11'd2;
    return sum[10] ? 8'hFF : sum[9:2];
  endfunction

endpackage

// File: rtl/itp_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write into a full FIFO lands if a read frees a slot that cycle.
module itp_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    valid,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             do_wr, do_rd;

  assign valid   = (cnt != '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & valid;
  assign do_wr   = wr_en & (~full | do_rd);
  // Data reads as zero while empty so stale entries never leak out after reset.
  assign rd_data = valid ? mem[rp] : '0;
  assign level   = cnt;

  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/itp_out_packer.sv
// Rounds interpolator results to pixels, tags line/frame ends, and queues them behind a valid/ready stream.
module itp_out_packer
  import itp_pkg::*;
#(
  parameter int SIZE_PIXEL = ITP_SIZE_PIXEL,
  parameter int SIZE_Y     = ITP_SIZE_Y,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int SIZE_CNT   = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic [SIZE_Y-1:0]             i_y,
  input  logic [SIZE_CNT-1:0]           i_line_len,
  input  logic [SIZE_CNT-1:0]           i_frame_lines,
  input  logic                          i_clr_ovf,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [SIZE_PIXEL-1:0]         o_pix,
  output logic                          o_eol,
  output logic                          o_eof,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_ovf
);

  function automatic logic [SIZE_CNT-1:0] nz(input logic [SIZE_CNT-1:0] v);
    return (v == '0) ? SIZE_CNT'(1) : v;
  endfunction

  // i_en delay line matching the interpolator pipeline
  logic [LATENCY-1:0] vld_pipe;
  logic               tail;

  if (LATENCY == 1) begin : g_dly1
    always_ff @(posedge clk)
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= i_en;
  end else begin : g_dlyn
    always_ff @(posedge clk)
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[LATENCY-2:0], i_en};
  end

  assign tail = vld_pipe[LATENCY-1];

  logic [SIZE_CNT-1:0] col, row, len_q, lines_q;
  logic                cap;
  logic                eol_c, eof_c;
  logic                s1_vld;
  itp_out_word_t       s1_word;

  always_comb begin
    eol_c = (col == len_q - SIZE_CNT'(1));
    eof_c = eol_c & (row == lines_q - SIZE_CNT'(1));
  end

  // Stage 1: capture sample and tags; counters advance even if the FIFO later drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_word <= '0;
      col     <= '0;
      row     <= '0;
      len_q   <= SIZE_CNT'(1);
      lines_q <= SIZE_CNT'(1);
      cap     <= 1'b1;
    end else begin
      s1_vld <= tail;
      // Geometry latched on the first cycle out of reset; no sample can be in flight then.
      if (cap) begin
        len_q   <= nz(i_line_len);
        lines_q <= nz(i_frame_lines);
        cap     <= 1'b0;
      end
      if (tail) begin
        s1_word <= '{eof: eof_c, eol: eol_c, pix: itp_round_clamp(i_y)};
        if (eol_c) begin
          col <= '0;
          if (eof_c) begin
            row     <= '0;
            len_q   <= nz(i_line_len);
            lines_q <= nz(i_frame_lines);
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Stage 2: FIFO write straight from stage 1
  itp_out_word_t out_word;
  logic          fifo_full;
  logic          ovf_set;

  itp_sync_fifo #(
    .WIDTH ($bits(itp_out_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s1_vld),
    .wr_data (s1_word),
    .rd_en   (i_ready),
    .rd_data (out_word),
    .valid   (o_valid),
    .full    (fifo_full),
    .level   (o_level)
  );

  assign ovf_set = s1_vld & fifo_full & ~(o_valid & i_ready);

  always_ff @(posedge clk) begin
    if (rst)            o_ovf <= 1'b0;
    else if (ovf_set)   o_ovf <= 1'b1;
    else if (i_clr_ovf) o_ovf <= 1'b0;
  end

  assign o_pix = out_word.pix;
  assign o_eol = out_word.eol;
  assign o_eof = out_word.eof;

endmodule
